i2c_target: RTL and testbench

//  I2C target (slave) endpoint: the responder on the bus driven by the team's command-based I2C controller.

---
 rtl/i2c_pkg.sv | 34 +++
 rtl/i2c_bus_sync.sv | 58 +++++
 rtl/i2c_target.sv | 257 +++++++++++++++++++++++++
 tb/tb_i2c_target.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the I2C target endpoint.
//   i2c_tgt_state_e  target FSM state encoding
//   ACK / NACK       SDA level driven or seen in the ninth-bit slot
//   GCALL_ADDR       7-bit general-call address
//   RW_READ          R/W bit value selecting a read transfer
//   addr_match()     address-byte compare, general call optional
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_RX,
    ST_RX_ACK,
    ST_TX,
    ST_TX_ACK,
    ST_IGNORE
  } i2c_tgt_state_e;

  localparam logic       ACK         = 1'b0;
  localparam logic       NACK        = 1'b1;
  localparam logic [6:0] GCALL_ADDR  = 7'h00;
  localparam logic       RW_READ     = 1'b1;
  localparam logic [2:0] BIT_CNT_TOP = 3'd7;

  // General call is only a write with address 0, so the full byte must be 0x00.
  function automatic logic addr_match(input logic [7:0] addr_byte,
                                      input logic [6:0] own_addr,
                                      input logic       gcall_en);
    return (addr_byte[7:1] == own_addr) ||
           (gcall_en && (addr_byte == {GCALL_ADDR, 1'b0}));
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: synchronizes SCL/SDA into clk_i and detects bus events.
//   clk_i, rst_i   system clock, async active-high reset
//   scl_i, sda_i   raw pin levels
//   sda_o          synchronized SDA level
//   scl_rise_o     1-cycle pulse on SCL rising edge
//   scl_fall_o     1-cycle pulse on SCL falling edge
//   start_o        1-cycle pulse, SDA fell while SCL held high
//   stop_o         1-cycle pulse, SDA rose while SCL held high
// Event outputs are combinational from the last stage, so a registered
// consumer reacts SYNC_STAGES+1 clocks after the pin edge.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;
  logic                   scl_s;
  logic                   sda_s;

  // Reset to the idle-bus level so release of reset never looks like an edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  assign sda_o      = sda_s;
  assign scl_rise_o = ~scl_prev_q & scl_s;
  assign scl_fall_o = scl_prev_q & ~scl_s;
  // SCL must be high on both samples so an SDA change racing an SCL edge
  // is treated as data, not as a bus condition.
  assign start_o    = scl_prev_q & scl_s & sda_prev_q & ~sda_s;
  assign stop_o     = scl_prev_q & scl_s & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_target.sv
// i2c_target: I2C target endpoint with 7-bit address match.
//   clk_i, rst_i     system clock, async active-high reset
//   scl_i, sda_i     bus pin levels
//   sda_oe_o         1 = pull SDA low
//   rx_data_o/rx_valid_o/rx_ready_i   write-byte handshake to consumer
//   tx_data_i/tx_req_o                read-byte source, tx_req_o pulses on latch
//   start_o, stop_o, overrun_o        1-cycle event pulses
//   busy_o           high from START until STOP
// Build option: I2C_TARGET_GCALL_EN also accepts address byte 0x00 as a write.
//
// state       | meaning
// ST_IDLE     | bus free or target reset, waiting for START
// ST_ADDR     | shifting in address byte
// ST_ADDR_ACK | driving address ACK for one SCL period
// ST_RX       | shifting in write byte
// ST_RX_ACK   | driving ACK/NACK for a write byte
// ST_TX       | driving read byte, MSB first
// ST_TX_ACK   | SDA released, sampling controller ACK
// ST_IGNORE   | not addressed or read ended, SDA released
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h7D,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_req_o,
  output logic       start_o,
  output logic       stop_o,
  output logic       overrun_o,
  output logic       busy_o
);

`ifdef I2C_TARGET_GCALL_EN
  localparam logic GCALL_EN = 1'b1;
`else
  localparam logic GCALL_EN = 1'b0;
`endif

  logic sda_s, scl_rise, scl_fall, bus_start, bus_stop;

  i2c_bus_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (bus_start),
    .stop_o     (bus_stop)
  );

  i2c_tgt_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       byte_done_q, byte_done_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       busy_q, busy_d;
  logic       start_pulse_q, start_pulse_d;
  logic       stop_pulse_q, stop_pulse_d;
  logic       overrun_q, overrun_d;
  logic       tx_req_q, tx_req_d;
  logic       addr_hit;

  assign addr_hit = addr_match(shift_q, TARGET_ADDR, GCALL_EN);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= BIT_CNT_TOP;
      byte_done_q   <= 1'b0;
      shift_q       <= '0;
      tx_shift_q    <= '0;
      sda_oe_q      <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      busy_q        <= 1'b0;
      start_pulse_q <= 1'b0;
      stop_pulse_q  <= 1'b0;
      overrun_q     <= 1'b0;
      tx_req_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_done_q   <= byte_done_d;
      shift_q       <= shift_d;
      tx_shift_q    <= tx_shift_d;
      sda_oe_q      <= sda_oe_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      busy_q        <= busy_d;
      start_pulse_q <= start_pulse_d;
      stop_pulse_q  <= stop_pulse_d;
      overrun_q     <= overrun_d;
      tx_req_q      <= tx_req_d;
    end
  end

  // Bit counter counts down 7..0 per byte; byte_done marks the eighth SCL
  // rise so the ACK slot begins on the following SCL fall.
  // sda_oe is written as ~level: pulling low drives a 0 (ACK or data 0).
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    byte_done_d   = byte_done_q;
    shift_d       = shift_q;
    tx_shift_d    = tx_shift_q;
    sda_oe_d      = sda_oe_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    busy_d        = busy_q;
    start_pulse_d = 1'b0;
    stop_pulse_d  = 1'b0;
    overrun_d     = 1'b0;
    tx_req_d      = 1'b0;

    if (rx_valid_q && rx_ready_i) begin
      rx_valid_d = 1'b0;
    end

    if (bus_stop) begin
      state_d      = ST_IDLE;
      busy_d       = 1'b0;
      sda_oe_d     = 1'b0;
      stop_pulse_d = 1'b1;
      bit_cnt_d    = BIT_CNT_TOP;
      byte_done_d  = 1'b0;
    end else if (bus_start) begin
      state_d       = ST_ADDR;
      busy_d        = 1'b1;
      start_pulse_d = 1'b1;
      bit_cnt_d     = BIT_CNT_TOP;
      byte_done_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_ADDR, ST_RX: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s};
            if (bit_cnt_q == 3'd0) byte_done_d = 1'b1;
            else                   bit_cnt_d   = bit_cnt_q - 3'd1;
          end else if (scl_fall && byte_done_q) begin
            byte_done_d = 1'b0;
            bit_cnt_d   = BIT_CNT_TOP;
            if (state_q == ST_ADDR) begin
              if (addr_hit) begin
                state_d  = ST_ADDR_ACK;
                sda_oe_d = ~ACK;
              end else begin
                state_d  = ST_IGNORE;
                sda_oe_d = ~NACK;
              end
            end else begin
              state_d = ST_RX_ACK;
              if (!rx_valid_q) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
                sda_oe_d   = ~ACK;
              end else begin
                sda_oe_d  = ~NACK;
                overrun_d = 1'b1;
              end
            end
          end
        end

        ST_ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = BIT_CNT_TOP;
            if (shift_q[0] == RW_READ) begin
              state_d    = ST_TX;
              tx_shift_d = tx_data_i;
              tx_req_d   = 1'b1;
              sda_oe_d   = ~tx_data_i[7];
            end else begin
              state_d  = ST_RX;
              sda_oe_d = 1'b0;
            end
          end
        end

        ST_RX_ACK: begin
          if (scl_fall) begin
            state_d  = ST_RX;
            sda_oe_d = 1'b0;
          end
        end

        ST_TX: begin
          if (scl_rise) begin
            if (bit_cnt_q == 3'd0) byte_done_d = 1'b1;
            else                   bit_cnt_d   = bit_cnt_q - 3'd1;
          end else if (scl_fall) begin
            if (byte_done_q) begin
              state_d     = ST_TX_ACK;
              byte_done_d = 1'b0;
              bit_cnt_d   = BIT_CNT_TOP;
              sda_oe_d    = 1'b0;
            end else begin
              // bit_cnt already stepped on the preceding rise
              sda_oe_d = ~tx_shift_q[bit_cnt_q];
            end
          end
        end

        ST_TX_ACK: begin
          if (scl_rise) begin
            shift_d     = {shift_q[6:0], sda_s};
            byte_done_d = 1'b1;
          end else if (scl_fall && byte_done_q) begin
            byte_done_d = 1'b0;
            bit_cnt_d   = BIT_CNT_TOP;
            if (shift_q[0] == ACK) begin
              state_d    = ST_TX;
              tx_shift_d = tx_data_i;
              tx_req_d   = 1'b1;
              sda_oe_d   = ~tx_data_i[7];
            end else begin
              state_d  = ST_IGNORE;
              sda_oe_d = 1'b0;
            end
          end
        end

        ST_IDLE, ST_IGNORE: begin
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign sda_oe_o   = sda_oe_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign tx_req_o   = tx_req_q;
  assign start_o    = start_pulse_q;
  assign stop_o     = stop_pulse_q;
  assign overrun_o  = overrun_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
module tb_i2c_target;

  localparam int Q = 20;  // clocks per quarter SCL period

  logic       clk_i;
  logic       rst_i;
  logic       scl_line;
  logic       sda_line;
  logic       sda_oe_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i;
  logic [7:0] tx_data_i;
  logic       tx_req_o;
  logic       start_o;
  logic       stop_o;
  logic       overrun_o;
  logic       busy_o;

  logic m_scl_low;
  logic m_sda_low;

  assign scl_line = ~m_scl_low;
  assign sda_line = ~(m_sda_low | sda_oe_o);

  i2c_target #(
    .TARGET_ADDR (7'h7D),
    .SYNC_STAGES (2)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .scl_i      (scl_line),
    .sda_i      (sda_line),
    .sda_oe_o   (sda_oe_o),
    .rx_data_o  (rx_data_o),
    .rx_valid_o (rx_valid_o),
    .rx_ready_i (rx_ready_i),
    .tx_data_i  (tx_data_i),
    .tx_req_o   (tx_req_o),
    .start_o    (start_o),
    .stop_o     (stop_o),
    .overrun_o  (overrun_o),
    .busy_o     (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_fail = 0;
  int cnt_start = 0, cnt_stop = 0, cnt_ovr = 0, cnt_txreq = 0;
  logic [7:0] exp_rx[$];

  logic [7:0] tx_tab [0:7] = '{8'h5A, 8'hC3, 8'h96, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  int tx_idx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: counts event pulses and scores every consumed write byte.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (start_o)   cnt_start++;
      if (stop_o)    cnt_stop++;
      if (overrun_o) cnt_ovr++;
      if (tx_req_o)  cnt_txreq++;
      if (rx_valid_o && rx_ready_i) begin
        if (exp_rx.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rx_unexpected: got 0x%0h, expected no byte", rx_data_o);
        end else begin
          chk("rx_byte", {24'd0, rx_data_o}, {24'd0, exp_rx.pop_front()});
        end
      end
    end
  end

  // Producer: advances to the next table entry after each tx_req_o.
  initial begin
    tx_idx    = 0;
    tx_data_i = tx_tab[0];
    forever begin
      @(negedge clk_i);
      if (tx_req_o) begin
        tx_idx    = (tx_idx + 1) & 7;
        tx_data_i = tx_tab[tx_idx];
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic wait_q();
    repeat (Q) @(posedge clk_i);
  endtask

  task automatic i2c_start();
    if (m_scl_low) begin
      m_sda_low = 1'b0; wait_q();
      m_scl_low = 1'b0; wait_q();
    end
    m_sda_low = 1'b1; wait_q();
    m_scl_low = 1'b1; wait_q();
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; wait_q();
    m_scl_low = 1'b0; wait_q();
    m_sda_low = 1'b0; wait_q(); wait_q();
  endtask

  task automatic send_bit(input logic b);
    m_sda_low = ~b;   wait_q();
    m_scl_low = 1'b0; wait_q(); wait_q();
    m_scl_low = 1'b1; wait_q();
  endtask

  task automatic recv_bit(output logic b);
    m_sda_low = 1'b0; wait_q();
    m_scl_low = 1'b0; wait_q();
    b = sda_line;     wait_q();
    m_scl_low = 1'b1; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] data, input logic exp_ack, input string name);
    logic a;
    for (int i = 7; i >= 0; i--) send_bit(data[i]);
    recv_bit(a);
    chk({name, "_ack"}, {31'd0, a}, {31'd0, exp_ack});
  endtask

  task automatic read_byte(output logic [7:0] data, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      data[i] = b;
    end
    send_bit(ack);
  endtask

  task automatic drain();
    @(posedge clk_i); #1 rx_ready_i = 1'b1;
    @(posedge clk_i); #1 rx_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
  endtask

  initial begin
    int s0, p0, o0, t0;
    logic [7:0] d;
    logic b;
    rst_i      = 1'b1;
    rx_ready_i = 1'b0;
    m_scl_low  = 1'b0;
    m_sda_low  = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_sda_oe",   {31'd0, sda_oe_o},   0);
    chk("rst_rx_data",  {24'd0, rx_data_o},  0);
    chk("rst_rx_valid", {31'd0, rx_valid_o}, 0);
    chk("rst_busy",     {31'd0, busy_o},     0);
    chk("rst_pulses",   {28'd0, start_o, stop_o, overrun_o, tx_req_o}, 0);
    @(posedge clk_i); #2 rst_i = 1'b0;
    wait_q();

    // 1: single write byte, held through STOP
    s0 = cnt_start; p0 = cnt_stop;
    i2c_start();
    chk("t1_busy_on", {31'd0, busy_o}, 1);
    write_byte(8'hFA, 1'b0, "t1_addr");
    write_byte(8'h0C, 1'b0, "t1_data");
    i2c_stop();
    chk("t1_rx_valid", {31'd0, rx_valid_o}, 1);
    chk("t1_rx_data",  {24'd0, rx_data_o}, 32'h0C);
    chk("t1_starts",   cnt_start - s0, 1);
    chk("t1_stops",    cnt_stop - p0, 1);
    chk("t1_busy_off", {31'd0, busy_o}, 0);
    exp_rx.push_back(8'h0C);
    drain();
    chk("t1_rx_cleared", {31'd0, rx_valid_o}, 0);

    // 2: foreign address, then general call
    i2c_start();
    write_byte(8'hA0, 1'b1, "t2_foreign");
    i2c_stop();
    chk("t2_no_rx", {31'd0, rx_valid_o}, 0);
    i2c_start();
`ifdef I2C_TARGET_GCALL_EN
    write_byte(8'h00, 1'b0, "t2_gcall");
    write_byte(8'h33, 1'b0, "t2_gcall_data");
    i2c_stop();
    chk("t2_gcall_valid", {31'd0, rx_valid_o}, 1);
    chk("t2_gcall_data",  {24'd0, rx_data_o}, 32'h33);
    exp_rx.push_back(8'h33);
    drain();
`else
    write_byte(8'h00, 1'b1, "t2_gcall");
    write_byte(8'h33, 1'b1, "t2_gcall_data");
    i2c_stop();
    chk("t2_gcall_no_rx", {31'd0, rx_valid_o}, 0);
`endif

    // 3: one-byte read ending with NACK
    t0 = cnt_txreq;
    i2c_start();
    write_byte(8'hFB, 1'b0, "t3_addr");
    read_byte(d, 1'b1);
    chk("t3_read",   {24'd0, d}, 32'h5A);
    chk("t3_txreq",  cnt_txreq - t0, 1);
    chk("t3_release", {31'd0, sda_oe_o}, 0);
    recv_bit(b);
    chk("t3_ignore_sda", {31'd0, b}, 1);
    i2c_stop();

    // 3b: two-byte read, ACK then NACK
    t0 = cnt_txreq;
    i2c_start();
    write_byte(8'hFB, 1'b0, "t3b_addr");
    read_byte(d, 1'b0);
    chk("t3b_read0", {24'd0, d}, 32'hC3);
    read_byte(d, 1'b1);
    chk("t3b_read1", {24'd0, d}, 32'h96);
    chk("t3b_txreq", cnt_txreq - t0, 2);
    i2c_stop();

    // 4: repeated START, streaming consumer
    s0 = cnt_start; p0 = cnt_stop;
    rx_ready_i = 1'b1;
    exp_rx.push_back(8'h15);
    exp_rx.push_back(8'h16);
    i2c_start();
    write_byte(8'hFA, 1'b0, "t4_addr0");
    i2c_start();
    write_byte(8'hFA, 1'b0, "t4_addr1");
    write_byte(8'h15, 1'b0, "t4_d0");
    write_byte(8'h16, 1'b0, "t4_d1");
    i2c_stop();
    rx_ready_i = 1'b0;
    chk("t4_starts", cnt_start - s0, 2);
    chk("t4_stops",  cnt_stop - p0, 1);
    chk("t4_drained", exp_rx.size(), 0);

    // 5: overrun while consumer stalled
    o0 = cnt_ovr;
    i2c_start();
    write_byte(8'hFA, 1'b0, "t5_addr");
    write_byte(8'h11, 1'b0, "t5_d0");
    write_byte(8'h22, 1'b1, "t5_d1");
    chk("t5_overrun", cnt_ovr - o0, 1);
    chk("t5_rx_data", {24'd0, rx_data_o}, 32'h11);
    i2c_stop();
    chk("t5_kept_valid", {31'd0, rx_valid_o}, 1);
    chk("t5_kept_data",  {24'd0, rx_data_o}, 32'h11);
    exp_rx.push_back(8'h11);
    drain();

    // 6: async reset while target drives SDA low during a read
    i2c_start();
    write_byte(8'hFB, 1'b0, "t6_addr");
    recv_bit(b);
    chk("t6_bit7", {31'd0, b}, 0);
    recv_bit(b);
    chk("t6_bit6", {31'd0, b}, 0);
    m_sda_low = 1'b0; wait_q();
    m_scl_low = 1'b0; wait_q();
    chk("t6_driving", {31'd0, sda_oe_o}, 1);
    @(posedge clk_i); #2 rst_i = 1'b1;
    #1;
    chk("t6_rst_release", {31'd0, sda_oe_o}, 0);
    repeat (2) @(posedge clk_i);
    #2 rst_i = 1'b0;
    wait_q();
    m_scl_low = 1'b1; wait_q();
    chk("t6_busy_after_rst", {31'd0, busy_o}, 0);
    write_byte(8'hFA, 1'b1, "t6_no_start");
    i2c_stop();
    i2c_start();
    write_byte(8'hFA, 1'b0, "t6_recover");
    i2c_stop();

    chk("scoreboard_empty", exp_rx.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
